// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data memory.
// Master 0 is the CPU load/store port, master 1 the DMA/debug port.
module dm_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m0_wdata,
  input  logic [AW-1:0] m0_pc,
  output logic          m0_ack,
  output logic [AW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [AW-1:0] m1_wdata,
  input  logic [AW-1:0] m1_pc,
  output logic          m1_ack,
  output logic [AW-1:0] m1_rdata,
  output logic          dm_ce,
  output logic          dm_we,
  output logic          dm_re,
  output logic [3:0]    dm_be,
  output logic [AW-1:0] dm_addr,
  output logic [AW-1:0] dm_din,
  output logic [AW-1:0] dm_pc,
  input  logic [AW-1:0] dm_dout,
  input  logic          dm_ready,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } st_e;

  st_e  st_q, st_d;
  logic last_q, last_d;
  logic own0, own1;

  // The reset cycle must neither ack nor strobe the DM.
  assign own0  = (st_q == OWN0) & ~reset;
  assign own1  = (st_q == OWN1) & ~reset;
  assign grant = {st_q == OWN1, st_q == OWN0};

  always_comb begin
    dm_ce   = 1'b0;
    dm_we   = 1'b0;
    dm_re   = 1'b0;
    dm_be   = '0;
    dm_addr = '0;
    dm_din  = '0;
    dm_pc   = '0;
    unique case (1'b1)
      own0: begin
        dm_ce   = m0_req;
        dm_we   = m0_req & m0_we;
        dm_re   = m0_req & ~m0_we;
        dm_be   = m0_req ? m0_be : 4'h0;
        dm_addr = m0_req ? m0_addr : '0;
        dm_din  = m0_req ? m0_wdata : '0;
        dm_pc   = m0_req ? m0_pc : '0;
      end
      own1: begin
        dm_ce   = m1_req;
        dm_we   = m1_req & m1_we;
        dm_re   = m1_req & ~m1_we;
        dm_be   = m1_req ? m1_be : 4'h0;
        dm_addr = m1_req ? m1_addr : '0;
        dm_din  = m1_req ? m1_wdata : '0;
        dm_pc   = m1_req ? m1_pc : '0;
      end
      default: ;
    endcase
  end

  assign m0_ack   = own0 & m0_req & dm_ready;
  assign m1_ack   = own1 & m1_req & dm_ready;
  assign m0_rdata = own0 ? dm_dout : '0;
  assign m1_rdata = own1 ? dm_dout : '0;

  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    unique case (st_q)
      IDLE: begin
        if (m0_req & m1_req)
          st_d = last_q ? OWN0 : OWN1;
        else if (m0_req)
          st_d = OWN0;
        else if (m1_req)
          st_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          st_d = IDLE;
        end else if (dm_ready) begin
          last_d = 1'b0;
          st_d   = m1_req ? OWN1 : OWN0;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          st_d = IDLE;
        end else if (dm_ready) begin
          last_d = 1'b1;
          st_d   = m0_req ? OWN0 : OWN1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      last_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a two-cycle sync-read DM model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_dm_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_be, m1_be;
  logic [AW-1:0] m0_addr, m0_wdata, m0_pc;
  logic [AW-1:0] m1_addr, m1_wdata, m1_pc;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] m0_rdata, m1_rdata;
  logic          dm_ce, dm_we, dm_re;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr, dm_din, dm_pc, dm_dout;
  logic          dm_ready;
  logic [1:0]    grant;

  logic [AW-1:0] mem [0:63];
  logic          wait_q = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_ce(dm_ce), .dm_we(dm_we), .dm_re(dm_re),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_pc(dm_pc), .dm_dout(dm_dout), .dm_ready(dm_ready),
    .grant(grant)
  );

  // DM model: ready low on the first cycle of each access.
  assign dm_ready = dm_ce & wait_q;
  assign dm_dout  = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    wait_q <= dm_ce & ~wait_q;
    if (dm_ce & dm_we & dm_ready)
      for (int b = 0; b < 4; b++)
        if (dm_be[b])
          mem[dm_addr[7:2]][8*b +: 8] <= dm_din[8*b +: 8];
  end

  task automatic chk(input string tag,
                     input logic [AW-1:0] got,
                     input logic [AW-1:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  task automatic drv0(input logic r, input logic w,
                      input logic [3:0] be,
                      input logic [AW-1:0] a,
                      input logic [AW-1:0] d,
                      input logic [AW-1:0] pc);
    m0_req = r; m0_we = w; m0_be = be;
    m0_addr = a; m0_wdata = d; m0_pc = pc;
  endtask

  task automatic drv1(input logic r, input logic w,
                      input logic [3:0] be,
                      input logic [AW-1:0] a,
                      input logic [AW-1:0] d,
                      input logic [AW-1:0] pc);
    m1_req = r; m1_we = w; m1_be = be;
    m1_addr = a; m1_wdata = d; m1_pc = pc;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int cyc;
    logic exp_m;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    drv0(1'b1, 1'b0, 4'hF, '0, '0, '0);
    drv1(1'b1, 1'b0, 4'hF, '0, '0, '0);

    // Reset with both masters requesting
    repeat (3) begin
      smp();
      chk("rst_grant", grant, 0);
      chk("rst_ce", dm_ce, 0);
      chk("rst_ack0", m0_ack, 0);
      chk("rst_ack1", m1_ack, 0);
    end
    nxt(); reset = 1'b0;
    smp(); chk("rel_idle", grant, 0);
    nxt();
    smp(); chk("first_grant", grant, 2'b01);
    nxt();
    drv0(1'b0, 1'b0, 4'h0, '0, '0, '0);
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("first_abort_ack", m0_ack, 0);
    chk("first_abort_ce", dm_ce, 0);
    nxt();
    smp(); chk("first_idle", grant, 0);

    // Simultaneous writes: m0 first (last=1), then m1
    nxt();
    drv0(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h100);
    drv1(1'b1, 1'b1, 4'h1, 32'h24, 32'h00000055, 32'h200);
    smp(); chk("sim_c0_grant", grant, 0);
    nxt();
    smp(); chk("sim_c1_grant", grant, 2'b01);
    chk("sim_c1_we", dm_we, 1);
    chk("sim_c1_addr", dm_addr, 32'h20);
    chk("sim_c1_din", dm_din, 32'h11223344);
    chk("sim_c1_pc", dm_pc, 32'h100);
    chk("sim_c1_ack0", m0_ack, 0);
    nxt();
    smp(); chk("sim_c2_ack0", m0_ack, 1);
    chk("sim_c2_ack1", m1_ack, 0);
    nxt();
    drv0(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("sim_c3_grant", grant, 2'b10);
    chk("sim_c3_addr", dm_addr, 32'h24);
    chk("sim_c3_be", dm_be, 4'h1);
    chk("sim_c3_pc", dm_pc, 32'h200);
    chk("sim_c3_ack1", m1_ack, 0);
    nxt();
    smp(); chk("sim_c4_ack1", m1_ack, 1);
    chk("sim_c4_ack0", m0_ack, 0);
    nxt();
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("sim_c5_ce", dm_ce, 0);
    nxt();
    smp(); chk("sim_idle", grant, 0);
    chk("sim_mem20", mem[8], 32'h11223344);
    chk("sim_mem24", mem[9], 32'h00000055);

    // Single read by m0
    nxt();
    drv0(1'b1, 1'b0, 4'h0, 32'h10, '0, 32'h104);
    smp(); chk("rd_c0_ce", dm_ce, 0);
    nxt();
    smp(); chk("rd_c1_grant", grant, 2'b01);
    chk("rd_c1_re", dm_re, 1);
    chk("rd_c1_we", dm_we, 0);
    chk("rd_c1_addr", dm_addr, 32'h10);
    chk("rd_c1_pc", dm_pc, 32'h104);
    chk("rd_c1_ack0", m0_ack, 0);
    nxt();
    smp(); chk("rd_c2_ack0", m0_ack, 1);
    chk("rd_c2_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("rd_c2_rdata1", m1_rdata, 0);
    nxt();
    drv0(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("rd_c3_ack0", m0_ack, 0);
    nxt();
    smp(); chk("rd_idle", grant, 0);

    // Abort of an m1 write; last must stay 0
    nxt();
    drv1(1'b1, 1'b1, 4'hF, 32'h30, 32'hAAAA5555, 32'h300);
    smp();
    nxt();
    smp(); chk("ab_c1_grant", grant, 2'b10);
    chk("ab_c1_we", dm_we, 1);
    chk("ab_c1_ack1", m1_ack, 0);
    nxt();
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("ab_c2_ack1", m1_ack, 0);
    chk("ab_c2_we", dm_we, 0);
    nxt();
    smp(); chk("ab_idle", grant, 0);
    chk("ab_mem30", mem[12], 0);

    // Tie right after the abort: m1 must win since last=0
    nxt();
    drv0(1'b1, 1'b0, 4'h0, 32'h10, '0, '0);
    drv1(1'b1, 1'b0, 4'h0, 32'h10, '0, '0);
    smp();
    nxt();
    smp(); chk("tie_grant", grant, 2'b10);
    nxt();
    smp(); chk("tie_ack1", m1_ack, 1);
    chk("tie_rdata1", m1_rdata, 32'hDEADBEEF);
    chk("tie_ack0", m0_ack, 0);
    chk("tie_rdata0", m0_rdata, 0);
    nxt();
    drv0(1'b0, 1'b0, 4'h0, '0, '0, '0);
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("tie_handoff", grant, 2'b01);
    chk("tie_ce", dm_ce, 0);
    nxt();
    smp(); chk("tie_idle", grant, 0);

    // Alternation: both masters requesting for 12 accesses
    nxt();
    drv0(1'b1, 1'b0, 4'h0, 32'h10, '0, '0);
    drv1(1'b1, 1'b0, 4'h0, 32'h20, '0, '0);
    n = 0;
    cyc = 0;
    exp_m = 1'b0;
    while (n < 12 && cyc < 80) begin
      smp();
      cyc++;
      if (m0_ack | m1_ack) begin
        chk("alt_excl", m0_ack & m1_ack, 0);
        chk("alt_order", m1_ack, exp_m);
        if (m0_ack) chk("alt_rd0", m0_rdata, 32'hDEADBEEF);
        else chk("alt_rd1", m1_rdata, 32'h11223344);
        exp_m = ~exp_m;
        n++;
      end
      nxt();
    end
    chk("alt_count", n, 12);
    drv0(1'b0, 1'b0, 4'h0, '0, '0, '0);
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    nxt();
    smp(); chk("alt_idle", grant, 0);

    // Reset in the middle of an m1 write
    nxt();
    drv1(1'b1, 1'b1, 4'hF, 32'h38, 32'h77, '0);
    smp();
    nxt();
    smp(); chk("rm_c1_grant", grant, 2'b10);
    chk("rm_c1_we", dm_we, 1);
    nxt();
    reset = 1'b1;
    smp(); chk("rm_c2_ack1", m1_ack, 0);
    chk("rm_c2_we", dm_we, 0);
    chk("rm_c2_ce", dm_ce, 0);
    nxt();
    smp(); chk("rm_c3_grant", grant, 0);
    chk("rm_c3_ce", dm_ce, 0);
    chk("rm_c3_addr", dm_addr, 0);
    chk("rm_c3_ack1", m1_ack, 0);
    chk("rm_mem38", mem[14], 0);
    nxt();
    reset = 1'b0;
    drv1(1'b0, 1'b0, 4'h0, '0, '0, '0);
    smp(); chk("rm_end_idle", grant, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter that shares the single-port data memory between the CPU load/store port (master 0) and a DMA/debug master (master 1). It sits directly in front of the DM and forwards exactly one master's request fields at a time. It holds the grant until the DM's `ready` completes that master's access, and it alternates fairly between the masters when both are requesting. Read data and completion are returned only to the owning master.

## Interface
- `AW`, default 32: address/data word width; all address and data buses are `AW` bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `m0_req`, `m1_req`  in  1  master requests an access; held until that master's ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_be`, `m1_be`  in  4  byte enables for writes.
- `m0_addr`, `m1_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  AW  write data.
- `m0_pc`, `m1_pc`  in  AW  tag forwarded to the DM trace.
- `m0_ack`, `m1_ack`  out  1  access completed this cycle.
- `m0_rdata`, `m1_rdata`  out  AW  read data; valid when the matching ack is 1.
- `dm_ce`, `dm_we`, `dm_re`  out  1  DM strobes.
- `dm_be`  out  4  DM byte enables.
- `dm_addr`, `dm_din`, `dm_pc`  out  AW  DM request fields.
- `dm_dout`  in  AW  DM read data.
- `dm_ready`  in  1  DM completion (combinational in the DM).
- `grant`  out  2  one-hot current owner; 2'b00 when idle.

## Operation
- State register `st` ∈ {IDLE, OWN0, OWN1}.
- A 1-bit `last` register holds the most recent master granted; reset value is 1, so master 0 wins the first tie.
- **IDLE**
  - All `dm_*` outputs are driven 0. No ack is given.
  - Next state when only one master requests: that master's OWN state.
  - Next state when both request: the master ≠ `last`.
  - Otherwise stay in IDLE.
- **OWNx: forwarding**
  - `dm_ce` = `mx_req`.
  - `dm_we` = `mx_req & mx_we`.
  - `dm_re` = `mx_req & ~mx_we`.
  - `dm_addr`, `dm_din`, `dm_be`, `dm_pc` are taken from master x; all are forced 0 when `mx_req` = 0.
- **OWNx: ack and read data**
  - `mx_ack` = `dm_ready & mx_req & (st == OWNx)`. The other master's ack is 0.
  - `mx_rdata` = `dm_dout` whenever `st` = OWNx; otherwise 0.
- **OWNx: transitions**
  - On an ack edge, `last` ← x. Next state is:
    - OWNy if `my_req` = 1 (round-robin handoff, no IDLE bubble);
    - else OWNx if `mx_req` = 1 (back-to-back access by the same master);
    - else IDLE.
  - If `mx_req` drops without an ack (abort), next state is IDLE and `last` is unchanged. No write occurs, because `dm_we` follows `mx_req`.
- A master's fields must be stable from `req` rising until its ack. The arbiter does not latch them.
- Write data is never merged here; byte masking is the DM's job.

## Timing
- **Reset values:** `st` = IDLE, `last` = 1, `grant` = 0. All `dm_*`, acks and rdata are 0.
- **Reset mid-access:** the state is forced to IDLE at the next edge, the grant is dropped, and no ack is given in the reset cycle.
- **Grant latency:** 1 cycle. A request sampled in IDLE at edge N is driven to the DM during cycle N+1.
- **Earliest ack:** the first OWN cycle, if `dm_ready` is high then. The DM's sync-read model typically lowers `ready` on the first cycle of a new address, so the usual access takes 2 cycles from grant.
- **Back-to-back:** same-master accesses and handoffs to the other master both take 0 idle cycles. The new owner is driven in the cycle after the ack.
- **Fairness:** with both masters continuously requesting, grants strictly alternate 0,1,0,1…. No master waits more than one complete access of the other.
- **Ack/grant exclusivity:** `m0_ack` and `m1_ack` are never both 1. `grant` is always one-hot or zero.
- **Isolation:** `dm_ready` high while IDLE produces no ack.

## Test plan
- **Reset:** drive `reset` = 1 with both requests high -> `grant` = 0, `dm_ce` = 0, and both acks = 0 throughout. After reset is released, the first grant is 2'b01.
- **Single read:** m0 reads `addr` = 0x10 (memory preloaded with 0xDEADBEEF at 0x10), m1 idle -> `grant` = 01 one cycle later, `dm_re` = 1, `dm_addr` = 0x10. `m0_ack` pulses for exactly one cycle with `m0_rdata` = 0xDEADBEEF. The state returns to IDLE.
- **Simultaneous requests:** m0 writes 0x11223344 to 0x20 with `be` = 4'hF while m1 writes 0x55 to 0x24 with `be` = 4'h1 -> m0 completes first, then `grant` switches to 10 on the next cycle with no IDLE bubble. Memory then holds 0x11223344 at 0x20 and 0x00000055 at 0x24.
- **Alternation:** both masters hold `req` high for 6 accesses each -> ack order is m0, m1, m0, m1, … with no two consecutive acks to the same master.
- **Abort:** m1 asserts `req` for a write to 0x30, then deasserts it before `dm_ready` -> `m1_ack` is never asserted, 0x30 stays unchanged, and the state returns to IDLE with `last` unchanged.
- **Reset mid-access:** assert `reset` during an OWN1 write -> no ack. The next edge gives `grant` = 0 and all `dm_*` = 0.
